pid_chan_scheduler: RTL and testbench

//  Round-robin scheduler that feeds the multi-channel PID filter from N_CHAN independent sample sources.

---
 rtl/pid_chan_scheduler_pkg.sv | 11 +
 rtl/pid_chan_scheduler_if.sv | 24 ++
 rtl/pid_chan_scheduler_rr_arbiter.sv | 32 +++
 rtl/pid_chan_scheduler.sv | 147 ++++++++++++++
 tb/tb_pid_chan_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pid_chan_scheduler_pkg.sv
// Shared constants for the PID filter front-end: channel count, index/data widths and pipe depth.
package pid_pkg;

    localparam int unsigned N_CHAN         = 8;
    localparam int unsigned W_CHAN         = 5;
    localparam int unsigned W_DATA         = 18;
    localparam int unsigned PID_PIPE_DEPTH = 6;
    localparam int unsigned W_OVR_CNT_DEF  = 16;
    localparam int unsigned CHAN_SEL_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

endpackage

// File: rtl/pid_chan_scheduler_if.sv
// Sample-in / filter-out bus of the channel scheduler; slave is the scheduler, master drives samples.
interface pid_chan_scheduler_if;
    import pid_pkg::*;

    logic [N_CHAN-1:0]        samp_dv_in;
    logic [N_CHAN*W_DATA-1:0] samp_data_in;
    logic [N_CHAN-1:0]        chan_en_in;
    logic                     pid_dv_out;
    logic [W_CHAN-1:0]        pid_chan_out;
    logic [W_DATA-1:0]        pid_data_out;
    logic [N_CHAN-1:0]        pending_out;
    logic [N_CHAN-1:0]        overrun_out;

    modport slave (
        input  samp_dv_in, samp_data_in, chan_en_in,
        output pid_dv_out, pid_chan_out, pid_data_out, pending_out, overrun_out
    );

    modport master (
        output samp_dv_in, samp_data_in, chan_en_in,
        input  pid_dv_out, pid_chan_out, pid_data_out, pending_out, overrun_out
    );

endinterface

// File: rtl/pid_chan_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request found from ptr_i+1 upward, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned W_IDX = 5
) (
    input  logic [N-1:0]     req_i,
    input  logic [W_IDX-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [W_IDX-1:0] idx_o,
    output logic             valid_o
);

    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [SEL_W-1:0] k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = SEL_W'((32'(ptr_i) + i) % N);
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = W_IDX'(k);
            end
        end
    end

endmodule

// File: rtl/pid_chan_scheduler.sv
// Round-robin feeder for the multi-channel PID filter with per-channel re-issue spacing.
// Optional per-channel overrun counters are built when SCHED_OVERRUN_CNT_EN is defined.
module pid_chan_scheduler
    import pid_pkg::*;
#(
    parameter int unsigned MIN_SPACING = PID_PIPE_DEPTH
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    parameter int unsigned W_OVR_CNT   = W_OVR_CNT_DEF
`endif
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    pid_chan_scheduler_if.slave   bus
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    input  logic [W_CHAN-1:0]     ovr_sel_in,
    output logic [W_OVR_CNT-1:0]  ovr_cnt_out
`endif
);

    localparam int unsigned W_COOL = (MIN_SPACING > 1) ? $clog2(MIN_SPACING) : 1;
    localparam logic [W_COOL-1:0] COOL_RELOAD = W_COOL'(MIN_SPACING - 1);

    logic [W_DATA-1:0] hold_q [N_CHAN];
    logic [W_DATA-1:0] hold_d [N_CHAN];
    logic [W_COOL-1:0] cool_q [N_CHAN];
    logic [W_COOL-1:0] cool_d [N_CHAN];
    logic [N_CHAN-1:0] pend_q, pend_d;
    logic [N_CHAN-1:0] ovr_q, ovr_d;
    logic [W_CHAN-1:0] ptr_q, ptr_d;
    logic              dv_q, dv_d;
    logic [W_CHAN-1:0] chan_q, chan_d;
    logic [W_DATA-1:0] data_q, data_d;

    logic [N_CHAN-1:0] elig;
    logic [N_CHAN-1:0] gnt;
    logic [W_CHAN-1:0] gnt_idx;
    logic              gnt_valid;

    always_comb begin
        elig = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            elig[k] = pend_q[k] & bus.chan_en_in[k] & (cool_q[k] == '0);
        end
    end

    rr_arbiter #(
        .N     (N_CHAN),
        .W_IDX (W_CHAN)
    ) u_arb (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_comb begin
        pend_d = pend_q;
        ovr_d  = '0;
        ptr_d  = gnt_valid ? gnt_idx : ptr_q;
        dv_d   = gnt_valid;
        chan_d = gnt_valid ? gnt_idx : chan_q;
        data_d = data_q;
        for (int k = 0; k < N_CHAN; k++) begin
            hold_d[k] = hold_q[k];
            cool_d[k] = cool_q[k];
            if (bus.samp_dv_in[k] && bus.chan_en_in[k]) begin
                hold_d[k] = bus.samp_data_in[k*W_DATA +: W_DATA];
            end
            // A capture coinciding with a grant keeps the channel pending for the new sample.
            if (!bus.chan_en_in[k]) begin
                pend_d[k] = 1'b0;
            end else if (bus.samp_dv_in[k]) begin
                pend_d[k] = 1'b1;
            end else if (gnt[k]) begin
                pend_d[k] = 1'b0;
            end
            ovr_d[k] = bus.samp_dv_in[k] & bus.chan_en_in[k] & pend_q[k] & ~gnt[k];
            if (gnt[k]) begin
                cool_d[k] = COOL_RELOAD;
                data_d    = hold_q[k];
            end else if (cool_q[k] != '0) begin
                cool_d[k] = cool_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_q <= '0;
            ovr_q  <= '0;
            ptr_q  <= W_CHAN'(N_CHAN - 1);
            dv_q   <= 1'b0;
            chan_q <= '0;
            data_q <= '0;
            for (int k = 0; k < N_CHAN; k++) begin
                hold_q[k] <= '0;
                cool_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            ptr_q  <= ptr_d;
            dv_q   <= dv_d;
            chan_q <= chan_d;
            data_q <= data_d;
            for (int k = 0; k < N_CHAN; k++) begin
                hold_q[k] <= hold_d[k];
                cool_q[k] <= cool_d[k];
            end
        end
    end

    assign bus.pid_dv_out   = dv_q;
    assign bus.pid_chan_out = chan_q;
    assign bus.pid_data_out = data_q;
    assign bus.pending_out  = pend_q;
    assign bus.overrun_out  = ovr_q;

`ifdef SCHED_OVERRUN_CNT_EN
    logic [W_OVR_CNT-1:0] cnt_q [N_CHAN];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < N_CHAN; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (ovr_d[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ovr_cnt_out = '0;
        if (ovr_sel_in < W_CHAN'(N_CHAN)) begin
            ovr_cnt_out = cnt_q[ovr_sel_in[CHAN_SEL_W-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_pid_chan_scheduler.sv
// Directed bench for pid_chan_scheduler; overrun counter checks run only with SCHED_OVERRUN_CNT_EN.
module tb_pid_chan_scheduler;
    import pid_pkg::*;

    logic clk_in;
    logic rst_n_in;
    int   n_checks;
    int   n_fail;

    pid_chan_scheduler_if bus ();

`ifdef SCHED_OVERRUN_CNT_EN
    logic [W_CHAN-1:0] ovr_sel_in;
    logic [3:0]        ovr_cnt_out;

    pid_chan_scheduler #(
        .MIN_SPACING (6),
        .W_OVR_CNT   (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .bus         (bus.slave),
        .ovr_sel_in  (ovr_sel_in),
        .ovr_cnt_out (ovr_cnt_out)
    );
`else
    pid_chan_scheduler #(
        .MIN_SPACING (6)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus.slave)
    );
`endif

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        bus.samp_dv_in = '0;
        rst_n_in = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n_in = 1'b0;
        bus.samp_dv_in   = '0;
        bus.samp_data_in = '0;
        bus.chan_en_in   = '1;
`ifdef SCHED_OVERRUN_CNT_EN
        ovr_sel_in = '0;
`endif
        #2;
        check("rst_dv", 64'(bus.pid_dv_out), 64'd0);
        check("rst_chan", 64'(bus.pid_chan_out), 64'd0);
        check("rst_data", 64'(bus.pid_data_out), 64'd0);
        check("rst_pend", 64'(bus.pending_out), 64'd0);
        check("rst_ovr", 64'(bus.overrun_out), 64'd0);
        step();
        rst_n_in = 1'b1;
        step();

        // 1: single sample on ch3
        bus.samp_dv_in = 8'h08;
        bus.samp_data_in[3*W_DATA +: W_DATA] = 18'h12345;
        step();
        bus.samp_dv_in = '0;
        check("t1_capture_dv", 64'(bus.pid_dv_out), 64'd0);
        check("t1_capture_pend", 64'(bus.pending_out), 64'h08);
        step();
        check("t1_dv", 64'(bus.pid_dv_out), 64'd1);
        check("t1_chan", 64'(bus.pid_chan_out), 64'd3);
        check("t1_data", 64'(bus.pid_data_out), 64'h12345);
        check("t1_pend", 64'(bus.pending_out), 64'd0);
        step();
        check("t1_single", 64'(bus.pid_dv_out), 64'd0);
        check("t1_hold_chan", 64'(bus.pid_chan_out), 64'd3);

        // 2: all channels at once, issued in order 0..7
        do_reset();
        for (int k = 0; k < N_CHAN; k++) begin
            bus.samp_data_in[k*W_DATA +: W_DATA] = W_DATA'(k);
        end
        bus.samp_dv_in = '1;
        step();
        bus.samp_dv_in = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            step();
            check("t2_dv", 64'(bus.pid_dv_out), 64'd1);
            check("t2_chan", 64'(bus.pid_chan_out), 64'(k));
            check("t2_data", 64'(bus.pid_data_out), 64'(k));
            check("t2_ovr", 64'(bus.overrun_out), 64'd0);
        end
        step();
        check("t2_idle", 64'(bus.pid_dv_out), 64'd0);

        // 3: ch2 strobed every cycle; issues every 6 cycles, overruns in between
        do_reset();
        for (int n = 1; n <= 14; n++) begin
            bus.samp_dv_in = 8'h04;
            bus.samp_data_in[2*W_DATA +: W_DATA] = W_DATA'(n);
            step();
            if (n >= 2) begin
                if ((n - 2) % 6 == 0) begin
                    check("t3_issue_dv", 64'(bus.pid_dv_out), 64'd1);
                    check("t3_issue_chan", 64'(bus.pid_chan_out), 64'd2);
                    check("t3_issue_data", 64'(bus.pid_data_out), 64'(n - 1));
                    check("t3_issue_ovr", 64'(bus.overrun_out), 64'd0);
                end else begin
                    check("t3_gap_dv", 64'(bus.pid_dv_out), 64'd0);
                    check("t3_gap_ovr", 64'(bus.overrun_out), 64'h04);
                end
            end
        end
        bus.samp_dv_in = '0;

        // 4: ch5 disabled one cycle before it would win
        do_reset();
        bus.samp_dv_in = 8'h30;
        step();
        bus.samp_dv_in = '0;
        bus.chan_en_in = 8'hDF;
        step();
        check("t4_dv", 64'(bus.pid_dv_out), 64'd1);
        check("t4_chan", 64'(bus.pid_chan_out), 64'd4);
        check("t4_pend", 64'(bus.pending_out), 64'd0);
        check("t4_ovr", 64'(bus.overrun_out), 64'd0);
        step();
        check("t4_no_issue", 64'(bus.pid_dv_out), 64'd0);
        check("t4_ovr2", 64'(bus.overrun_out), 64'd0);
        bus.chan_en_in = '1;
        step();
        check("t4_reenable", 64'(bus.pid_dv_out), 64'd0);

        // 5: reset mid-burst clears outputs asynchronously
        do_reset();
        for (int k = 0; k < N_CHAN; k++) begin
            bus.samp_data_in[k*W_DATA +: W_DATA] = W_DATA'(k + 256);
        end
        bus.samp_dv_in = '1;
        step();
        bus.samp_dv_in = '0;
        step();
        step();
        step();
        check("t5_pre_chan", 64'(bus.pid_chan_out), 64'd2);
        rst_n_in = 1'b0;
        #1;
        check("t5_async_dv", 64'(bus.pid_dv_out), 64'd0);
        check("t5_async_chan", 64'(bus.pid_chan_out), 64'd0);
        check("t5_async_data", 64'(bus.pid_data_out), 64'd0);
        check("t5_async_pend", 64'(bus.pending_out), 64'd0);
        step();
        rst_n_in = 1'b1;
        step();
        check("t5_no_partial", 64'(bus.pid_dv_out), 64'd0);
        bus.samp_dv_in = 8'h81;
        step();
        bus.samp_dv_in = '0;
        step();
        check("t5_first_dv", 64'(bus.pid_dv_out), 64'd1);
        check("t5_first_chan", 64'(bus.pid_chan_out), 64'd0);
        check("t5_first_data", 64'(bus.pid_data_out), 64'd256);
        step();
        check("t5_second_chan", 64'(bus.pid_chan_out), 64'd7);
        check("t5_second_data", 64'(bus.pid_data_out), 64'd263);

`ifdef SCHED_OVERRUN_CNT_EN
        // 6: ch1 overrun counter saturates at 4'hF
        do_reset();
        bus.samp_dv_in = 8'h02;
        for (int n = 0; n < 40; n++) begin
            step();
        end
        bus.samp_dv_in = '0;
        step();
        ovr_sel_in = 5'd1;
        #1;
        check("t6_cnt_ch1", 64'(ovr_cnt_out), 64'hF);
        ovr_sel_in = 5'd0;
        #1;
        check("t6_cnt_ch0", 64'(ovr_cnt_out), 64'h0);
        ovr_sel_in = 5'd9;
        #1;
        check("t6_cnt_oob", 64'(ovr_cnt_out), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
